// File: rtl/ceespu_fetch.sv
// Instruction fetch stage for the ceespu pipeline.
//
// Sits between the PC stage and decode. Each cycle it decides whether the
// current PC can be consumed (issued to the synchronous instruction memory),
// and captures the word returned one cycle later, together with its PC, into
// a 2-entry buffer. The PC stage is backpressured through O_pc_stall, and a
// branch flush discards both the buffered words and the word still in flight.
//
// Decode handshake: O_valid means O_instr/O_instr_PC hold a real instruction.
// Decode takes it in any cycle where O_valid=1 and I_stall=0 (a "pop"). While
// I_stall=1 the head entry is held unchanged. Outputs read as zero when
// O_valid=0. A flush or reset cycle never counts as a pop.
module ceespu_fetch #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_PC,
  input  logic              I_flush,
  input  logic              I_stall,
  input  logic [DATA_W-1:0] I_imem_data,
  output logic [ADDR_W-1:0] O_imem_addr,
  output logic              O_imem_en,
  output logic              O_pc_stall,
  output logic              O_valid,
  output logic [DATA_W-1:0] O_instr,
  output logic [ADDR_W-1:0] O_instr_PC
);

  // Buffer occupancy (0..2) and the one outstanding memory read.
  logic [1:0]        count_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  // Head is the older entry; tail is only meaningful when count_q == 2.
  logic [DATA_W-1:0] head_instr_q;
  logic [ADDR_W-1:0] head_pc_q;
  logic [DATA_W-1:0] tail_instr_q;
  logic [ADDR_W-1:0] tail_pc_q;

  logic       pop;
  logic       push;
  logic       kill;
  logic       issue;
  logic [2:0] occ_next;

  // A read may be issued only if, after this cycle's pop, the buffer plus the
  // in-flight word leaves room for one more returning word. This keeps
  // count_q + inflight_q <= 2, so the buffer can never overflow.
  assign kill     = I_rst | I_flush;
  assign pop      = O_valid & ~I_stall;
  assign push     = inflight_q;
  assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = ~kill & (occ_next <= 3'd1);

  assign O_imem_addr = I_PC;
  assign O_imem_en   = issue;
  assign O_pc_stall  = ~issue;

  assign O_valid    = (count_q != 2'd0);
  assign O_instr    = O_valid ? head_instr_q : '0;
  assign O_instr_PC = O_valid ? head_pc_q    : '0;

  // Occupancy and in-flight tracking; reset and flush both empty the stage.
  always_ff @(posedge I_clk) begin
    if (kill) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_q + {1'b0, push} - {1'b0, pop};
      inflight_q <= issue;
    end
  end

  // Remember which PC the outstanding read belongs to.
  always_ff @(posedge I_clk) begin
    if (issue) begin
      inflight_pc_q <= I_PC;
    end
  end

  // Buffer data movement: pop shifts tail to head, push fills the first free
  // slot after the pop. Contents are don't-care when not counted.
  always_ff @(posedge I_clk) begin
    if (!kill) begin
      if (pop) begin
        if (count_q == 2'd2) begin
          head_instr_q <= tail_instr_q;
          head_pc_q    <= tail_pc_q;
          if (push) begin
            tail_instr_q <= I_imem_data;
            tail_pc_q    <= inflight_pc_q;
          end
        end else if (push) begin
          head_instr_q <= I_imem_data;
          head_pc_q    <= inflight_pc_q;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_instr_q <= I_imem_data;
          head_pc_q    <= inflight_pc_q;
        end else begin
          tail_instr_q <= I_imem_data;
          tail_pc_q    <= inflight_pc_q;
        end
      end
    end
  end

endmodule
